// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types for the data-memory arbiter
package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        S_EXEC  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE    = 2'd0,
        GNT_EXEC_RD = 2'd1,
        GNT_EXEC_WR = 2'd2,
        GNT_HOST    = 2'd3
    } gnt_t;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - exec/host arbiter for the single-port data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int HOST_MAX_WAIT   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_exec_rd_req,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_exec_rd_addr,
    input  logic                       in_exec_wr_req,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_exec_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_exec_wr_word,
    output logic                       out_stall,
    input  logic                       in_host_req,
    input  logic                       in_host_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_host_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_host_wr_word,
    output logic                       out_host_ack,
    output logic [DMEM_WORD_WIDTH-1:0] out_host_rd_word,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
    output logic                       out_mem_we,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word
);

    localparam int WCW = $clog2(HOST_MAX_WAIT + 1);

    state_t         state;
    state_t         state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           host_ack;
    logic           host_rd_pend;

    gnt_t           gnt;
    gnt_t           gnt_eff;
    logic           stall_c;
    logic           host_live;
    logic           wait_full;

    // A request still high during its own ack cycle is stale, not a new one.
    assign host_live = in_host_req && !host_ack;
    assign wait_full = (wait_cnt == WCW'(HOST_MAX_WAIT));

    always_comb begin
        gnt       = GNT_NONE;
        stall_c   = 1'b0;
        state_nxt = S_EXEC;
        case (state)
            S_SPLIT: begin
                gnt = GNT_EXEC_RD;
            end
            default: begin
                if (host_live && wait_full) begin
                    gnt     = GNT_HOST;
                    stall_c = in_exec_rd_req || in_exec_wr_req;
                end else if (in_exec_wr_req) begin
                    gnt = GNT_EXEC_WR;
                    if (in_exec_rd_req) begin
                        stall_c   = 1'b1;
                        state_nxt = S_SPLIT;
                    end
                end else if (in_exec_rd_req) begin
                    gnt = GNT_EXEC_RD;
                end else if (host_live) begin
                    gnt = GNT_HOST;
                end
            end
        endcase
    end

    // Outputs are forced quiet for as long as reset is held, not just at the edge.
    assign gnt_eff   = reset ? GNT_NONE : gnt;
    assign out_stall = reset ? 1'b0 : stall_c;

    always_comb begin
        out_mem_addr    = '0;
        out_mem_we      = 1'b0;
        out_mem_wr_word = '0;
        case (gnt_eff)
            GNT_EXEC_RD: begin
                out_mem_addr = in_exec_rd_addr;
            end
            GNT_EXEC_WR: begin
                out_mem_addr    = in_exec_wr_addr;
                out_mem_we      = 1'b1;
                out_mem_wr_word = in_exec_wr_word;
            end
            GNT_HOST: begin
                out_mem_addr = in_host_addr;
                out_mem_we   = in_host_we;
                if (in_host_we) begin
                    out_mem_wr_word = in_host_wr_word;
                end
            end
            default: begin
                out_mem_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_EXEC;
            wait_cnt     <= '0;
            host_ack     <= 1'b0;
            host_rd_pend <= 1'b0;
        end else begin
            state        <= state_nxt;
            host_ack     <= (gnt == GNT_HOST);
            host_rd_pend <= (gnt == GNT_HOST) && !in_host_we;
            if ((gnt == GNT_HOST) || !host_live) begin
                wait_cnt <= '0;
            end else if (!wait_full) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
        end
    end

    assign out_host_ack     = host_ack;
    assign out_host_rd_word = (host_ack && host_rd_pend) ? in_mem_rd_word : '0;

endmodule
